// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: funnels NUM_REQ level-held interrupt requests into a single
// downstream interrupt channel. Only one downstream interrupt is outstanding at a
// time. The requester's ack is held until both the downstream ack and the
// requester's own request have dropped.
// Optional build macro INTERRUPT_ARB_FIXED_PRIO_EN: selects fixed priority
// (lowest index wins). When the macro is undefined, round-robin is used.

// Per-requester ack cell: a lane acks only while the arbiter is in RELEASE
// and the lane holds the grant. At most one lane can match grant_id.
module interrupt_arbiter_lane #(
  parameter int IDX = 0
) (
  input  logic       release_st,
  input  logic [2:0] grant_id,
  output logic       ack
);
  assign ack = release_st && (grant_id == 3'(IDX));
endmodule

module interrupt_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_interrupt,
  input  logic [64*NUM_REQ-1:0] req_interrupt_src,
  output logic [NUM_REQ-1:0]   req_interrupt_ack,
  output logic                 interrupt,
  output logic [63:0]          interrupt_src,
  input  logic                 interrupt_ack,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Requests are zero-padded to 8 bits so that the 3-bit indices can address
  // them directly for any NUM_REQ value.
  logic [7:0]                  req_pad;
  logic                        any_req;
  logic [2:0]                  win;
  logic [63:0]                 win_src;
  logic [NUM_REQ-1:0][63:0]    src_arr;

  assign req_pad = 8'(req_interrupt);
  assign any_req = |req_interrupt;
  assign src_arr = req_interrupt_src;

`ifdef INTERRUPT_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    win = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req_interrupt[i]) win = 3'(i);
  end
`else
  logic [2:0] last_served;
  logic [2:0] idx;
  logic       found;

  // Round-robin: scan from last_served+1 with wraparound and take the first requester that is high.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 3'((int'(last_served) + k) % NUM_REQ);
      if (!found && req_pad[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Record the served requester when its transaction retires to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_served <= 3'(NUM_REQ-1);
    else if (state == RELEASE && state_nxt == IDLE)
      last_served <= grant_id;
  end
`endif

  // Source mux for the winning requester.
  always_comb begin
    win_src = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == 3'(i)) win_src = src_arr[i];
  end

  // Next-state logic. RELEASE waits for the downstream ack and the granted request to both drop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)       state_nxt = ISSUE;
      ISSUE:   if (interrupt_ack) state_nxt = RELEASE;
      RELEASE: if (!interrupt_ack && !req_pad[grant_id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the grant and its source on the IDLE->ISSUE transition only. This
  // keeps the downstream source frozen for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id      <= '0;
      interrupt_src <= '0;
    end else if (state == IDLE && any_req) begin
      grant_id      <= win;
      interrupt_src <= win_src;
    end
  end

  assign interrupt = (state == ISSUE);
  assign busy      = (state != IDLE);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    interrupt_arbiter_lane #(.IDX(g)) u_lane (
      .release_st (state == RELEASE),
      .grant_id   (grant_id),
      .ack        (req_interrupt_ack[g])
    );
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of interrupt requesters (2..8).
REQ-002 SHALL have port: clk  in  1  single clock for all logic.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_interrupt  in  NUM_REQ  per-requester interrupt request, level, held until its ack.
REQ-005 SHALL have port: req_interrupt_src  in  64*NUM_REQ  per-requester 64-bit source object; requester i occupies bits [64i+63:64i].
REQ-006 SHALL have port: req_interrupt_ack  out  NUM_REQ  per-requester acknowledge.
REQ-007 SHALL have port: interrupt  out  1  request to the downstream interrupt TLX engine.
REQ-008 SHALL have port: interrupt_src  out  64  source object presented downstream.
REQ-009 SHALL have port: interrupt_ack  in  1  downstream acknowledge; high from the done/fail response until `interrupt` drops.
REQ-010 SHALL have port: grant_id  out  3  index of the currently granted requester.
REQ-011 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, ISSUE and RELEASE in one registered state machine.
REQ-013 IDLE: if any req_interrupt bit is high, SHALL select a winner, latch its index into grant_id, latch its src into interrupt_src, and enter ISSUE next cycle; otherwise SHALL stay in IDLE.
REQ-014 Winner selection SHALL be round-robin: scan indices last_served+1, +2, ... modulo NUM_REQ and take the first requester with its bit high.
REQ-015 ISSUE: `interrupt` SHALL be 1. When interrupt_ack=1, SHALL enter RELEASE next cycle.
REQ-016 interrupt_src SHALL be stable from the ISSUE entry until the next IDLE->ISSUE transition; src changes on the requester side SHALL be ignored.
REQ-017 RELEASE: `interrupt` SHALL be 0 and req_interrupt_ack[grant_id] SHALL be 1; all other ack bits SHALL be 0.
REQ-018 RELEASE SHALL exit to IDLE only when interrupt_ack=0 and req_interrupt[grant_id]=0 in the same cycle. On that transition last_served SHALL be set to grant_id.
REQ-019 `interrupt`, interrupt_src, req_interrupt_ack and busy SHALL be driven from registers or from the state register only, with no combinational path from inputs.
REQ-020 Latency SHALL be 1 cycle from a request sampled in IDLE to interrupt=1, and 1 cycle from interrupt_ack=1 to the requester ack.
REQ-021 If the granted requester drops req_interrupt while in ISSUE, the block SHALL still complete the downstream transaction; the ack SHALL then be a single-cycle pulse in RELEASE, provided interrupt_ack is already 0.
REQ-022 Requests arriving in ISSUE or RELEASE SHALL wait; at most one downstream interrupt SHALL be outstanding.
REQ-023 A requester re-asserting immediately after release SHALL compete normally in the next IDLE cycle.
REQ-024 Simultaneous new requests SHALL be resolved only by REQ-014; ack bits SHALL never have more than one bit set.

Reset
REQ-025 While rst_n=0: state SHALL be IDLE; interrupt, interrupt_src, req_interrupt_ack, busy and grant_id SHALL be 0; last_served SHALL be NUM_REQ-1.
REQ-026 Reset asserted mid-ISSUE or mid-RELEASE SHALL abandon the transaction with no ack; no state SHALL be retained.

Configuration
REQ-027 With macro INTERRUPT_ARB_FIXED_PRIO_EN defined, winner selection SHALL be fixed priority, lowest index first, and last_served SHALL be unused. Without the macro, REQ-014 round-robin SHALL apply.

Verification
REQ-028 req 2 with src 0x0000_0000_0000_1234; interrupt_ack high 5 cycles after issue -> interrupt=1 with src 0x1234 one cycle after the request; req_interrupt_ack=4'b0100 until req 2 drops; then IDLE with busy=0.
REQ-029 After reset, all four requests high and held -> grant order 0, 1, 2, 3; each grant has exactly one downstream interrupt.
REQ-030 req 0 re-requests continuously while req 3 pends from the start -> 0 then 3 served, then 0 again; req 3 is never starved.
REQ-031 interrupt_ack held 10 cycles after req 1 drops -> stays in RELEASE and no new interrupt is issued until interrupt_ack=0, even with req 0 pending.
REQ-032 rst_n pulsed low during ISSUE -> all outputs 0 immediately; next request sequence starts from index 0.
REQ-033 With INTERRUPT_ARB_FIXED_PRIO_EN defined, reqs 1 and 3 high and req 1 re-requesting -> req 1 always wins; req 3 is served only once req 1 stays low in an IDLE cycle.
